block_or_pipe: RTL
==================

# block_or_pipe

Parametrised multi-channel successor to the two-register OR block: `CH` independent channels, each computing the bitwise OR of two `W`-bit operands, carried through a `DEPTH`-stage registered pipeline with valid/ready flow control. A single clock and asynchronous active-low reset replace the per-channel clocks. Per-channel enables allow selective update. The block sits between a producer and consumer that both use the standard valid/ready handshake.

## Interface
Parameters:
- `CH`, 2, number of channels (≥1)
- `W`, 1, operand/result width per channel (≥1)
- `DEPTH`, 1, pipeline stages (≥1)

Ports:
- `c`  input  1  clock, rising edge
- `rn`  input  1  reset, asynchronous, active-low
- `in_valid`  input  1  producer has a sample
- `in_ready`  output  1  block accepts sample this cycle
- `a`  input  CH*W  operand A; channel i at bits [i*W +: W]
- `b`  input  CH*W  operand B, same packing
- `ce`  input  CH  per-channel update enable, sampled with the accepted sample
- `clr`  input  1  accumulator clear; sticky build only, ignored otherwise
- `out_valid`  output  1  stage DEPTH-1 holds a sample
- `out_ready`  input  1  consumer accepts
- `o`  output  CH*W  result of stage DEPTH-1, same packing

## Operation
- Stages 0..DEPTH-1 each hold valid bit `v[k]` and data `d[k]` (CH*W bits).
- Stage readiness is bubble-collapsing:
  - `rdy[DEPTH-1] = !v[DEPTH-1] | out_ready`
  - `rdy[k] = !v[k] | rdy[k+1]`
  - `in_ready = rdy[0]`. This is a combinational path from `out_ready`.
- Accept: `in_valid & in_ready`. On accept, stage 0 loads `v[0]=1`. Per channel i:
  - `ce[i]=1`: `d[0]_i = a_i | b_i`
  - `ce[i]=0`: `d[0]_i` keeps its previous value. This is the last value loaded into stage 0 for that channel, even if that sample has since moved on.
- Stage k>0 loads `d[k-1]` and `v[k-1]` whenever `rdy[k]=1`.
- Stage 0 clears `v[0]` when `rdy[0]=1` and there is no accept.
- Data in empty stages is don't-care, but it must retain its last value. `ce=0` depends on the stage-0 retained value.
- `out_valid = v[DEPTH-1]`, `o = d[DEPTH-1]`.
- While `out_valid=1 & out_ready=0`, `o` is stable.
- No sample is dropped or duplicated. Order is preserved.

## Timing
- Reset (`rn=0`, async assert): all `v`=0 and all `d`=0. Therefore `out_valid=0`, `o=0`, and `in_ready=1`.
- Reset deassertion is synchronised externally. Reset mid-transfer discards all in-flight samples.
- Latency with `out_ready=1` held: a sample accepted at edge n appears on `o`/`out_valid` after edge n+DEPTH-1. It is visible DEPTH cycles after being presented.
- Throughput: 1 sample/cycle when `out_ready=1`.
- Full: all DEPTH stages valid and `out_ready=0` gives `in_ready=0`.
- Full with `out_ready=1`: accept and drain occur in the same cycle. Occupancy is unchanged.
- Capacity: DEPTH samples.

## Configuration
- Macro `BLOCK_OR_PIPE_STICKY_EN`.
- **Defined:** stage 0 accumulates. On accept, per channel:
  - `ce[i]=1`: `d[0]_i = acc_i | a_i | b_i`
  - `ce[i]=0`: `d[0]_i = acc_i`
  - Here `acc_i` is the previous `d[0]_i`, or 0 if `clr=1` that cycle.
- **`clr` with no accept:** `d[0]` is zeroed at the edge. `v[0]` is unaffected. Samples already in stages ≥1 are unaffected.
- **`clr` with accept:** clear takes priority over old content, so the new value is the current `a|b` (masked by `ce`).
- **Not defined:** behaviour is exactly as in Operation; the `clr` port exists but has no effect.

## Test plan
- Reset: assert `rn=0` mid-stream with DEPTH=3 stages full → `out_valid=0`, `o=0`, and `in_ready=1` immediately, without a clock edge.
- Basic OR (CH=2, W=4, DEPTH=2): `a=0x31`, `b=0x42`, `ce=2'b11`, `out_ready=1` → `o=0x73` with `out_valid=1` two cycles after acceptance; one sample per cycle for 8 consecutive samples, in order.
- Backpressure (DEPTH=3): hold `out_ready=0` and offer 5 samples → exactly 3 accepted, then `in_ready=0`. `o` stays stable. Release → remaining samples emerge in order with none lost or duplicated.
- Channel enable (CH=2, W=4): accept `a=0xFF`, `b=0`, `ce=11`, then `a=0x00`, `b=0x11`, `ce=01` → second output is `0xF1`; channel 1 retains `0xF`.
- Sticky (macro on, CH=1, W=4): accept 0x1, 0x2, 0x4 → outputs 0x1, 0x3, 0x7. Next, assert `clr` together with an accept of 0x8 → output 0x8. Then `clr` alone, followed by an accept with `ce=0` → output 0x0.
- Sticky off: repeat the sticky sequence → outputs 0x1, 0x2, 0x4, 0x8; `clr` has no effect.

Source files
------------

// File: rtl/block_or_pipe.sv
// -----------------------------------------------------------------------------
// block_or_pipe
//
// Purpose:
//   CH independent channels. Each channel computes the bitwise OR of two W-bit
//   operands. The results travel through a DEPTH-stage registered pipeline.
//   Flow control is valid/ready on both sides, and stage readiness is
//   bubble-collapsing. A per-channel enable (ce) selects which channels of
//   stage 0 are updated when a sample is accepted. Channels that are not
//   enabled keep the value last loaded into stage 0.
//
// Configuration:
//   BLOCK_OR_PIPE_STICKY_EN
//     Undefined (default): plain OR. The clr port is ignored.
//     Defined: stage 0 accumulates. On accept, each channel becomes
//     acc | a | b when ce=1, or acc when ce=0. acc is the previous stage-0
//     content, or zero when clr=1. When clr=1 and nothing is accepted,
//     stage-0 data is zeroed and its valid bit is left untouched.
//
// Parameters:
//   CH     number of channels (>=1)
//   W      operand/result width per channel (>=1)
//   DEPTH  pipeline stages (>=1)
//
// Ports:
//   c          clock, rising edge
//   rn         asynchronous active-low reset
//   in_valid   producer has a sample
//   in_ready   block accepts a sample this cycle (combinational from out_ready)
//   a, b       operands, channel i at bits [i*W +: W]
//   ce         per-channel update enable, sampled with the accepted sample
//   clr        accumulator clear (sticky build only)
//   out_valid  last stage holds a sample
//   out_ready  consumer accepts
//   o          data of the last stage, same packing as a/b
// -----------------------------------------------------------------------------
module block_or_pipe #(
   parameter int CH    = 2,
   parameter int W     = 1,
   parameter int DEPTH = 1
) (
   input  logic            c,
   input  logic            rn,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [CH*W-1:0] a,
   input  logic [CH*W-1:0] b,
   input  logic [CH-1:0]   ce,
   input  logic            clr,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [CH*W-1:0] o
);

   logic [DEPTH-1:0] v;
   logic [CH*W-1:0]  d [DEPTH];
   logic [DEPTH-1:0] rdy;
   logic             accept;
   logic [CH*W-1:0]  d0_next;

   // Readiness ripples back from the consumer. An empty stage can always
   // take new data, so bubbles collapse instead of stalling the producer.
   always_comb begin
      // NOTE: every variable driven in always_comb gets a default first.
      // Otherwise a path that misses an assignment would infer a latch.
      rdy            = '0;
      rdy[DEPTH-1]   = !v[DEPTH-1] | out_ready;
      for (int k = DEPTH - 2; k >= 0; k--) begin
         rdy[k] = !v[k] | rdy[k+1];
      end
   end

   assign in_ready  = rdy[0];
   assign accept    = in_valid & rdy[0];
   assign out_valid = v[DEPTH-1];
   assign o         = d[DEPTH-1];

   // Next content of stage-0 data. When nothing is loaded, stage-0 data keeps
   // its old value, even after its sample has moved on. A later ce=0 channel
   // reuses that value.
`ifdef BLOCK_OR_PIPE_STICKY_EN
   always_comb begin
      d0_next = d[0];
      // clr takes priority over old content, both with and without an accept.
      if (clr) begin
         d0_next = '0;
      end
      if (accept) begin
         for (int i = 0; i < CH; i++) begin
            if (ce[i]) begin
               d0_next[i*W +: W] = d0_next[i*W +: W] | a[i*W +: W] | b[i*W +: W];
            end
         end
      end
   end
`else
   logic unused_clr;
   assign unused_clr = clr;

   always_comb begin
      d0_next = d[0];
      if (accept) begin
         for (int i = 0; i < CH; i++) begin
            if (ce[i]) begin
               d0_next[i*W +: W] = a[i*W +: W] | b[i*W +: W];
            end
         end
      end
   end
`endif

   // Pipeline registers. Stage 0 is filled from the producer. Stage k>0 takes
   // stage k-1 whenever it is ready, so a full pipe with out_ready=1 shifts by
   // one and accepts one sample at the same edge.
   always_ff @(posedge c or negedge rn) begin
      if (!rn) begin
         v <= '0;
         // NOTE: the data array is reset too, not only the valid bits,
         // because o must read zero straight out of reset.
         for (int k = 0; k < DEPTH; k++) begin
            d[k] <= '0;
         end
      end else begin
         // NOTE: sequential state uses non-blocking assignment. Every stage
         // then samples its predecessor's pre-edge value, whatever the
         // statement order.
         v[0] <= accept | (v[0] & !rdy[0]);
         d[0] <= d0_next;
         for (int k = 1; k < DEPTH; k++) begin
            if (rdy[k]) begin
               v[k] <= v[k-1];
               d[k] <= d[k-1];
            end
         end
      end
   end

endmodule
